// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: one-hot sequencer for the multi-cycle A/Q/M ALU datapath (add, sub, shift-add mul, restoring div).
// Latency: add/sub done 4 cycles after start, mul 2*WIDTH+3, div 3*WIDTH+3; outputs are combinational state decodes.
// Backpressure: none; start is sampled only in IDLE and ignored while busy. Optional macro ALU_SEQ_DIVZERO_EN adds m_zero/err.
module alu_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] op,
    input  logic       q_lsb,
    input  logic       a_sign,
`ifdef ALU_SEQ_DIVZERO_EN
    input  logic       m_zero,
    output logic       err,
`endif
    output logic       ld_operands,
    output logic       add_en,
    output logic       sub_en,
    output logic       shift_en,
    output logic       restore_en,
    output logic       set_q0,
    output logic       out_en,
    output logic       busy,
    output logic       done
);

    // One flip-flop per state; IDLE is the only bit set after reset.
    typedef enum logic [9:0] {
        IDLE      = 10'b00_0000_0001,
        LOAD      = 10'b00_0000_0010,
        ADDSUB    = 10'b00_0000_0100,
        MUL_ADD   = 10'b00_0000_1000,
        MUL_SHIFT = 10'b00_0001_0000,
        DIV_SHIFT = 10'b00_0010_0000,
        DIV_SUB   = 10'b00_0100_0000,
        DIV_FIX   = 10'b00_1000_0000,
        OUTPUT    = 10'b01_0000_0000,
        DONE      = 10'b10_0000_0000
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       op_reg;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             last_iter;
    logic             div_zero;

    assign last_iter = (cnt == LAST_ITER);

`ifdef ALU_SEQ_DIVZERO_EN
    logic dz_reg;
    assign div_zero = m_zero;
    // Flag a zero-divisor bypass so err can accompany the done pulse it produces.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dz_reg <= 1'b0;
        end else if (state == LOAD) begin
            dz_reg <= (op_reg == OP_DIV) && m_zero;
        end else if (state == IDLE) begin
            dz_reg <= 1'b0;
        end
    end
    assign err = (state == DONE) && dz_reg;
`else
    assign div_zero = 1'b0;
`endif

    // Next-state and strobe decode; any illegal encoding drives all strobes low and returns to IDLE.
    always_comb begin
        state_nxt   = IDLE;
        ld_operands = 1'b0;
        add_en      = 1'b0;
        sub_en      = 1'b0;
        shift_en    = 1'b0;
        restore_en  = 1'b0;
        set_q0      = 1'b0;
        out_en      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = start ? LOAD : IDLE;
            end
            LOAD: begin
                busy        = 1'b1;
                ld_operands = 1'b1;
                cnt_clr     = 1'b1;
                case (op_reg)
                    OP_MUL:  state_nxt = MUL_ADD;
                    OP_DIV:  state_nxt = div_zero ? DONE : DIV_SHIFT;
                    default: state_nxt = ADDSUB;
                endcase
            end
            ADDSUB: begin
                busy      = 1'b1;
                add_en    = (op_reg == OP_ADD);
                sub_en    = (op_reg == OP_SUB);
                state_nxt = OUTPUT;
            end
            MUL_ADD: begin
                busy      = 1'b1;
                add_en    = q_lsb;
                state_nxt = MUL_SHIFT;
            end
            MUL_SHIFT: begin
                busy      = 1'b1;
                shift_en  = 1'b1;
                cnt_inc   = 1'b1;
                state_nxt = last_iter ? OUTPUT : MUL_ADD;
            end
            DIV_SHIFT: begin
                busy      = 1'b1;
                shift_en  = 1'b1;
                state_nxt = DIV_SUB;
            end
            DIV_SUB: begin
                busy      = 1'b1;
                sub_en    = 1'b1;
                state_nxt = DIV_FIX;
            end
            DIV_FIX: begin
                busy       = 1'b1;
                restore_en = a_sign;
                set_q0     = ~a_sign;
                cnt_inc    = 1'b1;
                state_nxt  = last_iter ? OUTPUT : DIV_SHIFT;
            end
            OUTPUT: begin
                busy      = 1'b1;
                out_en    = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register, op capture in IDLE and the iteration counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            op_reg <= 2'b00;
        end else begin
            state <= state_nxt;
            if ((state == IDLE) && start) begin
                op_reg <= op;
            end
            if (cnt_clr) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: phase-count reference model compared every cycle, plus literal latency/pulse-count checks.
// Covers add, sub, mul, div, held start, mid-operation reset and (with ALU_SEQ_DIVZERO_EN) divide-by-zero bypass.
// Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
module tb_alu_seq_ctrl;

    localparam int W = 8;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] op;
    logic       q_lsb;
    logic       a_sign;
    logic       m_zero_tb;
    logic       ld_operands, add_en, sub_en, shift_en, restore_en, set_q0, out_en, busy, done;
    logic       err_w;

    int errors = 0;
    int checks = 0;

    alu_seq_ctrl #(.WIDTH(W), .CNT_W(3)) dut (
        .clk        (clk),
        .reset      (rst),
        .start      (start),
        .op         (op),
        .q_lsb      (q_lsb),
        .a_sign     (a_sign),
`ifdef ALU_SEQ_DIVZERO_EN
        .m_zero     (m_zero_tb),
        .err        (err_w),
`endif
        .ld_operands(ld_operands),
        .add_en     (add_en),
        .sub_en     (sub_en),
        .shift_en   (shift_en),
        .restore_en (restore_en),
        .set_q0     (set_q0),
        .out_en     (out_en),
        .busy       (busy),
        .done       (done)
    );

`ifndef ALU_SEQ_DIVZERO_EN
    assign err_w = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model: transaction phase k since start was accepted ----------------
    bit         active = 0;
    int         k = 0;
    logic [1:0] mop = 2'b00;
    bit         mdz = 0;

    function automatic int last_k(input logic [1:0] o, input bit dz);
        case (o)
            2'b00, 2'b01: return 4;
            2'b10:        return 2 * W + 3;
            default:      return dz ? 2 : 3 * W + 3;
        endcase
    endfunction

    // {ld, add, sub, shift, restore, setq, out, busy, done, err}
    function automatic logic [9:0] model_out(input bit act, input int kk, input logic [1:0] o,
                                             input bit dz, input logic q, input logic a);
        logic [9:0] v;
        int lk;
        v = '0;
        if (act) begin
            lk   = last_k(o, dz);
            v[2] = 1'b1;
            if (kk == 1) v[9] = 1'b1;
            else if (kk == lk) begin v[1] = 1'b1; v[0] = dz; end
            else if (kk == lk - 1) v[3] = 1'b1;
            else begin
                case (o)
                    2'b00: v[8] = 1'b1;
                    2'b01: v[7] = 1'b1;
                    2'b10: if (((kk - 2) % 2) == 0) v[8] = q; else v[6] = 1'b1;
                    default: begin
                        if (((kk - 2) % 3) == 0) v[6] = 1'b1;
                        else if (((kk - 2) % 3) == 1) v[7] = 1'b1;
                        else begin v[5] = a; v[4] = ~a; end
                    end
                endcase
            end
        end
        return v;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            active = 0;
            k      = 0;
        end else if (active) begin
            if (k == 1) mdz = (mop == 2'b11) && m_zero_tb;
            if (k == last_k(mop, mdz)) begin active = 0; k = 0; end
            else k = k + 1;
        end else if (start) begin
            active = 1;
            k      = 1;
            mop    = op;
            mdz    = 0;
        end
    end

    // ---------------- per-cycle compare and pulse counters ----------------
    int cnt_ld, cnt_add, cnt_sub, cnt_shift, cnt_restore, cnt_setq, cnt_done, cnt_err;
    logic [9:0] act_vec, exp_vec;

    always @(negedge clk) begin
        act_vec = {ld_operands, add_en, sub_en, shift_en, restore_en, set_q0, out_en, busy, done, err_w};
        exp_vec = model_out(active, k, mop, mdz, q_lsb, a_sign);
        checks++;
        if (act_vec !== exp_vec) begin
            errors++;
            $display("FAIL cycle_outputs t=%0t k=%0d got=%b expected=%b", $time, k, act_vec, exp_vec);
        end
        cnt_ld      += int'(ld_operands);
        cnt_add     += int'(add_en);
        cnt_sub     += int'(sub_en);
        cnt_shift   += int'(shift_en);
        cnt_restore += int'(restore_en);
        cnt_setq    += int'(set_q0);
        cnt_done    += int'(done);
        cnt_err     += int'(err_w);
    end

    // ---------------- helpers ----------------
    logic [7:0] qpat = 8'b1011_0101;   // bit i = q_lsb in multiply iteration i
    logic [7:0] apat = 8'b0101_0101;   // bit i = a_sign in divide iteration i

    task automatic chk(input string name, input int got, input int expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (k >= 2) begin
            q_lsb  = qpat[((k - 2) / 2) % 8];
            a_sign = apat[((k - 2) / 3) % 8];
        end else begin
            q_lsb  = 1'b0;
            a_sign = 1'b0;
        end
    endtask

    task automatic clr_counts();
        cnt_ld = 0; cnt_add = 0; cnt_sub = 0; cnt_shift = 0;
        cnt_restore = 0; cnt_setq = 0; cnt_done = 0; cnt_err = 0;
    endtask

    // Start one operation from IDLE and return the cycle index at which done is seen (-1 if never).
    task automatic run_op(input logic [1:0] o, output int done_k);
        clr_counts();
        op    = o;
        start = 1'b1;
        tick();
        start = 1'b0;
        done_k = -1;
        for (int n = 1; n <= 60; n++) begin
            if (done) begin done_k = n; break; end
            tick();
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int dk, nld, second, guard;
        rst = 1'b0; start = 1'b0; op = 2'b00; q_lsb = 1'b0; a_sign = 1'b0; m_zero_tb = 1'b0;
        clr_counts();
        #1 rst = 1'b1;
        tick(); tick();
        chk("reset_outputs", int'({ld_operands, add_en, sub_en, shift_en, restore_en, set_q0, out_en, busy, done, err_w}), 0);
        rst = 1'b0;
        tick();
        chk("idle_busy", int'(busy), 0);

        run_op(2'b00, dk);
        chk("add_done_k", dk, 4);
        chk("add_pulses", cnt_add, 1);
        chk("add_ld", cnt_ld, 1);

        run_op(2'b01, dk);
        chk("sub_done_k", dk, 4);
        chk("sub_pulses", cnt_sub, 1);

        run_op(2'b10, dk);
        chk("mul_done_k", dk, 19);
        chk("mul_add_count", cnt_add, 5);
        chk("mul_shift_count", cnt_shift, 8);

        run_op(2'b11, dk);
        chk("div_done_k", dk, 27);
        chk("div_restore_count", cnt_restore, 4);
        chk("div_setq_count", cnt_setq, 4);
        chk("div_shift_count", cnt_shift, 8);
        chk("div_sub_count", cnt_sub, 8);

        // start held high, op wiggled while busy
        clr_counts();
        op = 2'b01; start = 1'b1;
        tick();
        nld = 0; second = -1;
        for (int n = 1; n <= 11; n++) begin
            if (ld_operands) begin nld++; if (nld == 2) second = n; end
            if (n == 2) op = 2'b10;
            if (n == 4) op = 2'b01;
            if (n < 11) tick();
        end
        start = 1'b0;
        chk("held_start_loads", nld, 3);
        chk("second_load_k", second, 6);
        guard = 0;
        while (busy && guard < 20) begin tick(); guard++; end
        chk("held_start_drain", int'(busy), 0);
        tick();

        // reset during the sixth MUL_SHIFT (counter = 5)
        clr_counts();
        op = 2'b10; start = 1'b1;
        tick();
        start = 1'b0;
        guard = 0;
        while (!(active && k == 13) && guard < 40) begin tick(); guard++; end
        chk("midreset_in_shift", int'(shift_en), 1);
        chk("midreset_prior_shifts", cnt_shift, 5);
        rst = 1'b1;
        #1;
        chk("midreset_async_zero", int'({ld_operands, add_en, sub_en, shift_en, restore_en, set_q0, out_en, busy, done, err_w}), 0);
        tick();
        rst = 1'b0;
        tick(); tick(); tick();
        chk("midreset_no_done", cnt_done, 0);
        run_op(2'b00, dk);
        chk("post_reset_add_k", dk, 4);

`ifdef ALU_SEQ_DIVZERO_EN
        m_zero_tb = 1'b1;
        run_op(2'b11, dk);
        chk("divzero_done_k", dk, 2);
        chk("divzero_err", cnt_err, 1);
        chk("divzero_no_shift", cnt_shift, 0);
        m_zero_tb = 1'b0;
        run_op(2'b11, dk);
        chk("div_nz_done_k", dk, 27);
        chk("div_nz_err", cnt_err, 0);
`endif

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
